// File: rtl/ccb_pkg.sv
// Shared types and constants for the CCB access requester.
package ccb_pkg;

    // Requester FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } ccb_state_e;

    // Bit positions within the two-bit arag handshake pair
    localparam int REQ_BIT = 1;
    localparam int GNT_BIT = 0;

endpackage

// File: rtl/ccb_req_fifo.sv
// Pending-word buffer for the CCB requester. DEPTH must be a power of two.
// Pointers wrap modulo DEPTH and the count is one bit wider than a pointer.
// A push offered while full is refused even if a pop happens in the same
// cycle, so "full" always reflects the count before that cycle's pop.
module ccb_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Word storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ccb_access_requester.sv
// CCB access requester: buffers local words, requests the bus through the
// arag req/gnt pair, drives up to BURST_MAX words per grant, then releases.
// Optional build macro CCB_REQ_TIMEOUT_EN adds a MAX_WAIT-cycle grant-wait
// timeout in REQ; without it REQ waits indefinitely.
module ccb_access_requester
    import ccb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_MAX  = 4,
    parameter int MAX_WAIT   = 64
) (
    input  logic              fastClk,
    input  logic              rstN,
    input  logic              wrValid,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrReady,
    output logic              aragReq,
    input  logic              aragGnt,
    output logic [DATA_W-1:0] ccbData,
    output logic              ccbValid,
    output logic              errPulse
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    ccb_state_e        state_q, state_d;
    logic              aragReq_q, aragReq_d;
    logic              ccbValid_q, ccbValid_d;
    logic [DATA_W-1:0] ccbData_q, ccbData_d;
    logic              errPulse_q, errPulse_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [1:0]        arag_w;
    logic              gnt_w;
    logic              push_w;
    logic              pop_w;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [DATA_W-1:0] fifo_rdata;
`ifdef CCB_REQ_TIMEOUT_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0]     wait_q, wait_d;
`endif

    assign arag_w[REQ_BIT] = aragReq_q;
    assign arag_w[GNT_BIT] = aragGnt;
    assign aragReq  = arag_w[REQ_BIT];
    assign gnt_w    = arag_w[GNT_BIT];
    assign wrReady  = ~fifo_full;
    assign push_w   = wrValid & ~fifo_full;
    assign ccbValid = ccbValid_q;
    assign ccbData  = ccbData_q;
    assign errPulse = errPulse_q;

    ccb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (fastClk),
        .rst_ni  (rstN),
        .push_i  (push_w),
        .wdata_i (wrData),
        .pop_i   (pop_w),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        aragReq_d  = aragReq_q;
        ccbValid_d = 1'b0;
        ccbData_d  = '0;
        errPulse_d = 1'b0;
        burst_d    = burst_q;
        pop_w      = 1'b0;
`ifdef CCB_REQ_TIMEOUT_EN
        wait_d     = wait_q;
`endif
        case (state_q)
            IDLE: begin
                aragReq_d = 1'b0;
                burst_d   = '0;
`ifdef CCB_REQ_TIMEOUT_EN
                wait_d    = '0;
`endif
                if (!fifo_empty) begin
                    state_d   = REQ;
                    aragReq_d = 1'b1;
                end
            end
            REQ: begin
                aragReq_d = 1'b1;
                if (gnt_w) begin
                    state_d = XFER;
                end
`ifdef CCB_REQ_TIMEOUT_EN
                else if (wait_q == WW'(MAX_WAIT - 1)) begin
                    aragReq_d  = 1'b0;
                    errPulse_d = 1'b1;
                    state_d    = REL;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            XFER: begin
                if (!gnt_w) begin
                    // Grant lost mid-burst: stop popping, flag it, release
                    errPulse_d = 1'b1;
                    aragReq_d  = 1'b0;
                    state_d    = REL;
                end else if (!fifo_empty) begin
                    pop_w      = 1'b1;
                    ccbValid_d = 1'b1;
                    ccbData_d  = fifo_rdata;
                    burst_d    = burst_q + 1'b1;
                    // Last word of the burst, or the buffer drains with this pop
                    if ((burst_q == BW'(BURST_MAX - 1)) ||
                        ((fifo_cnt == CW'(1)) && !push_w)) begin
                        aragReq_d = 1'b0;
                        state_d   = REL;
                    end
                end else begin
                    aragReq_d = 1'b0;
                    state_d   = REL;
                end
            end
            REL: begin
                aragReq_d = 1'b0;
                if (!gnt_w) begin
                    state_d = IDLE;
                end
            end
            default: begin
                aragReq_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge fastClk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            aragReq_q  <= 1'b0;
            ccbValid_q <= 1'b0;
            ccbData_q  <= '0;
            errPulse_q <= 1'b0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            aragReq_q  <= aragReq_d;
            ccbValid_q <= ccbValid_d;
            ccbData_q  <= ccbData_d;
            errPulse_q <= errPulse_d;
            burst_q    <= burst_d;
        end
    end

`ifdef CCB_REQ_TIMEOUT_EN
    // Grant-wait counter, cleared in IDLE and advanced in REQ
    always_ff @(posedge fastClk or negedge rstN) begin
        if (!rstN) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

endmodule

// File: tb/tb_ccb_access_requester.sv
// Self-checking bench for ccb_access_requester (default parameters).
// A negedge monitor keeps a queue model of buffered words; scenario tasks
// drive and sample one time unit after each rising edge.
module tb_ccb_access_requester;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BURST_MAX  = 4;
    localparam int MAX_WAIT   = 64;

    logic              fastClk = 1'b0;
    logic              rstN;
    logic              wrValid;
    logic [DATA_W-1:0] wrData;
    logic              wrReady;
    logic              aragReq;
    logic              aragGnt;
    logic [DATA_W-1:0] ccbData;
    logic              ccbValid;
    logic              errPulse;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q[$];
    bit                mon_en = 1'b0;
    int                run_len = 0;
    int                tot_out = 0;
    logic              exp_rdy;

    ccb_access_requester #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_MAX  (BURST_MAX),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .fastClk  (fastClk),
        .rstN     (rstN),
        .wrValid  (wrValid),
        .wrData   (wrData),
        .wrReady  (wrReady),
        .aragReq  (aragReq),
        .aragGnt  (aragGnt),
        .ccbData  (ccbData),
        .ccbValid (ccbValid),
        .errPulse (errPulse)
    );

    always #5 fastClk = ~fastClk;

    // Buffer model: word order, burst length, idle data, wrReady
    always @(negedge fastClk) begin
        if (mon_en) begin
            checks++;
            if (!ccbValid && ccbData !== '0) begin
                errors++;
                $display("FAIL idle_data: got %0h expected 0", ccbData);
            end
            if (ccbValid) begin
                tot_out++;
                run_len++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL word_order: got %0h expected no word", ccbData);
                end else begin
                    if (ccbData !== q[0]) begin
                        errors++;
                        $display("FAIL word_order: got %0h expected %0h", ccbData, q[0]);
                    end
                    void'(q.pop_front());
                end
                checks++;
                if (run_len > BURST_MAX) begin
                    errors++;
                    $display("FAIL burst_len: got %0d expected <= %0d", run_len, BURST_MAX);
                end
            end else begin
                run_len = 0;
            end
            exp_rdy = (q.size() < FIFO_DEPTH);
            checks++;
            if (wrReady !== exp_rdy) begin
                errors++;
                $display("FAIL wr_ready: got %b expected %b", wrReady, exp_rdy);
            end
            if (wrValid && q.size() < FIFO_DEPTH) q.push_back(wrData);
        end
    end

    task automatic step();
        @(posedge fastClk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        int t;
        t = 0;
        wrValid = 1'b1;
        wrData  = d;
        while (!wrReady && t < 300) begin
            step();
            t++;
        end
        checks++;
        if (!wrReady) begin
            errors++;
            $display("FAIL push_timeout: got wrReady=%b expected 1", wrReady);
        end
        step();
        wrValid = 1'b0;
        wrData  = '0;
    endtask

    // Controller: wait for request, grant after delay, collect the burst,
    // then drop grant and count request-low cycles before the next request.
    task automatic do_grant(input int delay, output int nwords, output int nerr,
                            output int low);
        int t;
        nwords = 0;
        nerr   = 0;
        low    = 0;
        t      = 0;
        while (!aragReq && t < 500) begin
            step();
            t++;
        end
        checks++;
        if (!aragReq) begin
            errors++;
            $display("FAIL req_timeout: got aragReq=%b expected 1", aragReq);
        end
        repeat (delay) step();
        aragGnt = 1'b1;
        t = 0;
        do begin
            step();
            if (ccbValid) nwords++;
            if (errPulse) nerr++;
            t++;
        end while (aragReq && t < 100);
        aragGnt = 1'b0;
        low = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ccbValid) nwords++;
            if (errPulse) nerr++;
            if (aragReq) break;
            low++;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; wrValid = 1'b0; wrData = '0; aragGnt = 1'b0;
        #1;
        checks++;
        if ({aragReq, ccbValid, ccbData, errPulse} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%0h/%b expected all 0",
                     aragReq, ccbValid, ccbData, errPulse);
        end
        step(); step();
        rstN = 1'b1;
        step();
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_wrready: got %b expected 1", wrReady);
        end
        checks++;
        if (aragReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", aragReq);
        end
        q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bad;
        bad = '0;
        wrValid = 1'b1; wrData = 8'hA1;
        step();
        checks++;
        if (aragReq !== 1'b0) begin
            errors++; $display("FAIL basic_req_early: got %b expected 0", aragReq);
        end
        wrData = 8'hB2;
        step();
        checks++;
        if (aragReq !== 1'b1) begin
            errors++; $display("FAIL basic_req_rise: got %b expected 1", aragReq);
        end
        wrValid = 1'b0; wrData = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (aragReq !== 1'b1 || ccbValid !== 1'b0) bad[i] = 1'b1;
        end
        checks++;
        if (bad !== '0) begin
            errors++; $display("FAIL basic_req_hold: got %b expected 0000", bad);
        end
        aragGnt = 1'b1;
        step();
        checks++;
        if (ccbValid !== 1'b0) begin
            errors++; $display("FAIL basic_first_gap: got %b expected 0", ccbValid);
        end
        step();
        checks++;
        if ({ccbValid, ccbData, aragReq} !== {1'b1, 8'hA1, 1'b1}) begin
            errors++; $display("FAIL basic_word0: got %b/%0h/%b expected 1/a1/1", ccbValid, ccbData, aragReq);
        end
        step();
        checks++;
        if ({ccbValid, ccbData, aragReq} !== {1'b1, 8'hB2, 1'b0}) begin
            errors++; $display("FAIL basic_word1: got %b/%0h/%b expected 1/b2/0", ccbValid, ccbData, aragReq);
        end
        step();
        checks++;
        if ({ccbValid, aragReq} !== 2'b00) begin
            errors++; $display("FAIL basic_done: got %b/%b expected 0/0", ccbValid, aragReq);
        end
        aragGnt = 1'b0;
        bad = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (aragReq !== 1'b0 || errPulse !== 1'b0) bad[i] = 1'b1;
        end
        checks++;
        if (bad !== '0) begin
            errors++; $display("FAIL basic_idle: got %b expected 0000", bad);
        end
    endtask

    task automatic test_burst_split();
        int n1, e1, l1, n2, e2, l2;
        int t;
        n1 = 0; e1 = 0; l1 = 0; n2 = 0; e2 = 0; l2 = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) push_word(DATA_W'(8'h10 + i));
            end
            begin
                t = 0;
                while (wrReady && t < 50) begin step(); t++; end
                do_grant(0, n1, e1, l1);
                do_grant(1, n2, e2, l2);
            end
        join
        checks++;
        if (n1 !== 4 || n2 !== 2) begin
            errors++; $display("FAIL split_words: got %0d+%0d expected 4+2", n1, n2);
        end
        checks++;
        if (l1 !== 2) begin
            errors++; $display("FAIL split_req_gap: got %0d low cycles expected 2", l1);
        end
        checks++;
        if (e1 + e2 !== 0) begin
            errors++; $display("FAIL split_err: got %0d expected 0", e1 + e2);
        end
    endtask

    task automatic test_full_push_pop();
        int n1, e1, l1, n2, e2, l2, bad;
        n1 = 0; e1 = 0; l1 = 0; n2 = 0; e2 = 0; l2 = 0; bad = 0;
        for (int i = 0; i < 4; i++) push_word(DATA_W'(8'h30 + i));
        wrValid = 1'b1; wrData = 8'h34;
        for (int i = 0; i < 3; i++) begin
            if (wrReady !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL full_wrready: got %0d ready cycles expected 0", bad);
        end
        fork
            begin
                push_word(8'h34);
                push_word(8'h35);
            end
            do_grant(0, n1, e1, l1);
        join
        do_grant(0, n2, e2, l2);
        checks++;
        if (n1 + n2 !== 6 || q.size() !== 0) begin
            errors++; $display("FAIL full_no_loss: got %0d words, %0d left expected 6, 0", n1 + n2, q.size());
        end
    endtask

    task automatic test_grant_drop();
        int seen, t, n, e, l;
        seen = 0; t = 0;
        for (int i = 0; i < 4; i++) push_word(DATA_W'(8'h50 + i));
        aragGnt = 1'b1;
        while (seen < 2 && t < 20) begin
            step();
            if (ccbValid) seen++;
            t++;
        end
        aragGnt = 1'b0;
        step();
        checks++;
        if ({ccbValid, errPulse, aragReq} !== 3'b010) begin
            errors++; $display("FAIL drop_abort: got %b/%b/%b expected 0/1/0", ccbValid, errPulse, aragReq);
        end
        step();
        checks++;
        if (errPulse !== 1'b0) begin
            errors++; $display("FAIL drop_err_once: got %b expected 0", errPulse);
        end
        checks++;
        if (q.size() !== 2) begin
            errors++; $display("FAIL drop_remaining: got %0d expected 2", q.size());
        end
        do_grant(1, n, e, l);
        checks++;
        if (n !== 2 || e !== 0) begin
            errors++; $display("FAIL drop_rerequest: got %0d words %0d err expected 2 words 0 err", n, e);
        end
    endtask

    task automatic test_timeout();
        int t, bad, n, e, l;
        t = 0; bad = 0;
        push_word(8'h77);
        while (!aragReq && t < 10) begin step(); t++; end
`ifdef CCB_REQ_TIMEOUT_EN
        for (int i = 1; i < MAX_WAIT; i++) begin
            step();
            if (aragReq !== 1'b1 || errPulse !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL tmo_early: got %0d bad cycles expected 0", bad);
        end
        step();
        checks++;
        if ({errPulse, aragReq} !== 2'b10) begin
            errors++; $display("FAIL tmo_fire: got %b/%b expected 1/0", errPulse, aragReq);
        end
`else
        for (int i = 0; i < 200; i++) begin
            step();
            if (aragReq !== 1'b1 || errPulse !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wait_forever: got %0d bad cycles expected 0", bad);
        end
`endif
        do_grant(0, n, e, l);
        checks++;
        if (n !== 1 || e !== 0) begin
            errors++; $display("FAIL tmo_drain: got %0d words %0d err expected 1 word 0 err", n, e);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int t, bad;
        t = 0; bad = 0;
        for (int i = 0; i < 4; i++) push_word(DATA_W'(8'h90 + i));
        aragGnt = 1'b1;
        while (!ccbValid && t < 20) begin step(); t++; end
        mon_en = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checks++;
        if ({aragReq, ccbValid, ccbData, errPulse} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%0h/%b expected all 0", aragReq, ccbValid, ccbData, errPulse);
        end
        aragGnt = 1'b0;
        q.delete();
        step(); step();
        rstN = 1'b1;
        step();
        checks++;
        if (wrReady !== 1'b1) begin
            errors++; $display("FAIL rst_wrready: got %b expected 1", wrReady);
        end
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (aragReq !== 1'b0 || ccbValid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rst_empty: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_random_traffic();
        int target, iter, n, e, l, bad;
        target = tot_out + 24;
        iter = 0; bad = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    push_word(DATA_W'($urandom));
                end
            end
            begin
                while (tot_out < target && iter < 60) begin
                    do_grant(int'($urandom_range(0, 4)), n, e, l);
                    if (n < 1 || n > BURST_MAX || e !== 0) bad++;
                    iter++;
                end
            end
        join
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rand_bursts: got %0d bad bursts expected 0", bad);
        end
        checks++;
        if (tot_out !== target || q.size() !== 0) begin
            errors++; $display("FAIL rand_drain: got %0d/%0d left %0d expected all drained", tot_out, target, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst_split();
        test_full_push_pop();
        test_grant_drop();
        test_timeout();
        test_reset_mid_xfer();
        test_random_traffic();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
